cdr_acq_ctrl: RTL and testbench
===============================

// Module: cdr_acq_ctrl
// PURPOSE
//   Acquisition/lock sequencer for the CDR loop. Monitors the MMPD phase error f_n on each sample_en strobe.
//   Gear-shifts the PI loop-filter gains: wide for acquisition, narrow for tracking.
//   Declares and drops lock, and clears the loop filter on (re)start or timeout.
//   Sits beside cdr_core: consumes sample_en/f_n, drives kp_shift/ki_shift and the loop-filter clear.
// PARAMETERS
//   WIN_LOG2    4     log2 strobes per error window (16)
//   ERR_W       16    width of signed f_n
//   LOCK_THR    256   window sum |f_n| < LOCK_THR -> "good" window
//   UNLOCK_THR  1024  window sum |f_n| >= UNLOCK_THR -> "bad" window; between = neutral
//   GEAR_WINS   4     consecutive good windows ACQ->TRACK
//   LOCK_WINS   8     consecutive good windows TRACK->LOCK
//   LOSS_WINS   2     consecutive bad windows TRACK/LOCK->ACQ
//   ACQ_TMO     64    windows spent in ACQ before restart
//   KP_ACQ/KI_ACQ 4/10   shifts in IDLE/ACQ;  KP_TRK/KI_TRK 6/12   shifts in TRACK/LOCK
// PORTS
//   clk        in   1          system clock
//   rst        in   1          asynchronous, active-high reset
//   en         in   1          controller enable (low forces IDLE)
//   sample_en  in   1          recovered-timing strobe (1 clk pulse)
//   f_n        in   ERR_W      signed phase error, valid on sample_en
//   kp_shift   out  4          proportional shift to loop filter
//   ki_shift   out  5          integral shift to loop filter
//   lf_clr     out  1          loop-filter/DCO-offset clear
//   locked     out  1          1 only in LOCK
//   state      out  2          IDLE=0 ACQ=1 TRACK=2 LOCK=3
//   win_sum    out  ERR_W+WIN_LOG2  last completed window sum (unsigned)
// BEHAVIOUR
//   Reset: state=IDLE, kp/ki=ACQ values, lf_clr=1, locked=0, win_sum=0, all counters 0.
//   Accumulator: on sample_en, acc += |f_n|. |-2^(ERR_W-1)| = 2^(ERR_W-1).
//     Width ERR_W+WIN_LOG2 unsigned; cannot overflow.
//   Window end: the 2^WIN_LOG2-th strobe's sample is included.
//     Next cycle: win_done pulse, win_sum = total, acc restarts from 0 (or from a strobe in that cycle).
//   Classification at win_done: good / bad / neutral.
//     good: good_run++, bad_run=0. bad: bad_run++, good_run=0. neutral: both runs=0.
//   Timing: state and gain outputs update on the cycle after win_done (2 clk after the final strobe).
//     Gains are therefore constant within a window.
//   IDLE: lf_clr=1 (level). On en=1 -> ACQ; lf_clr drops as the state leaves IDLE. tmo=0.
//   ACQ: ACQ gains. Each window tmo++.
//     good_run==GEAR_WINS -> TRACK.
//     Otherwise tmo==ACQ_TMO -> stay ACQ, 1-cycle lf_clr pulse, runs/tmo cleared.
//     Gear-shift beats timeout in the same window.
//   TRACK: TRK gains. good_run==LOCK_WINS -> LOCK. bad_run==LOSS_WINS -> ACQ (no clear, tmo=0).
//   LOCK: TRK gains, locked=1. bad_run==LOSS_WINS -> ACQ with 1-cycle lf_clr pulse, tmo=0.
//   Run counters clear on every state change.
//   en=0 in any state: IDLE next cycle; acc, strobe count, runs and tmo cleared.
//     en=0 overrides a coincident window-end transition.
//   Async rst mid-window: immediate return to reset values; partial window discarded.
//   sample_en while en=0 is ignored.
// STRUCTURE
//   Package cdr_ctrl_pkg: state encodings, default gain shifts, threshold defaults.
//   Sub-module cdr_win_err_acc: |f_n| accumulator, strobe counter, win_done/win_sum.
//     Inputs: clk, rst, clr, sample_en, f_n.
//   Top: FSM + run/timeout counters + gain mux. All outputs registered.
// TESTING
//   1. Reset, en=1, f_n=0 each strobe -> ACQ.
//      After 4 windows (64 strobes) -> TRACK, kp=6/ki=12.
//      After 8 more -> LOCK, locked=1.
//   2. From LOCK, f_n=+100 for 32 strobes (sum 1600/window) -> ACQ after 2 windows.
//      lf_clr high exactly 1 cycle; kp=4.
//   3. f_n=+40 in ACQ (sum 640, neutral) -> no gear-shift.
//      After 64 windows: lf_clr 1-cycle pulse, still ACQ.
//   4. f_n=-32768 for a full window -> win_sum=524288, no overflow, classified bad.
//   5. Deassert en on the cycle of a 4th good win_done -> IDLE, not TRACK. lf_clr=1.
//   6. Assert rst mid-window (8 strobes in) -> outputs at reset values immediately.
//      After release, the first window needs 16 fresh strobes.

Source files
------------

// File: rtl/cdr_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cdr_ctrl_pkg
//   Shared definitions for the CDR acquisition/lock sequencer:
//   - cdr_state_t : controller state encoding (IDLE=0 ACQ=1 TRACK=2 LOCK=3)
//   - win_cls_t   : per-window error classification
//   - default window/threshold/run-length parameters
//   - loop-filter gain shifts for the wide (acquisition) and narrow
//     (tracking) gears, plus helpers that map a state to its gains
// ---------------------------------------------------------------------------
package cdr_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACQ   = 2'd1,
    ST_TRACK = 2'd2,
    ST_LOCK  = 2'd3
  } cdr_state_t;

  typedef enum logic [1:0] {
    CLS_NEUTRAL = 2'd0,
    CLS_GOOD    = 2'd1,
    CLS_BAD     = 2'd2
  } win_cls_t;

  // Default parameter values
  localparam int WIN_LOG2_DEF   = 4;
  localparam int ERR_W_DEF      = 16;
  localparam int LOCK_THR_DEF   = 256;
  localparam int UNLOCK_THR_DEF = 1024;
  localparam int GEAR_WINS_DEF  = 4;
  localparam int LOCK_WINS_DEF  = 8;
  localparam int LOSS_WINS_DEF  = 2;
  localparam int ACQ_TMO_DEF    = 64;

  // Run counters saturate; 8 bits comfortably covers every run threshold.
  localparam int RUN_W = 8;

  // Loop-filter shifts: larger shift = smaller gain.
  localparam logic [3:0] KP_ACQ = 4'd4;
  localparam logic [4:0] KI_ACQ = 5'd10;
  localparam logic [3:0] KP_TRK = 4'd6;
  localparam logic [4:0] KI_TRK = 5'd12;

  // IDLE and ACQ use the wide gear, TRACK and LOCK the narrow one.
  function automatic logic [3:0] kp_for(input cdr_state_t s);
    return ((s == ST_TRACK) || (s == ST_LOCK)) ? KP_TRK : KP_ACQ;
  endfunction

  function automatic logic [4:0] ki_for(input cdr_state_t s);
    return ((s == ST_TRACK) || (s == ST_LOCK)) ? KI_TRK : KI_ACQ;
  endfunction

endpackage

// File: rtl/cdr_win_err_acc.sv
// ---------------------------------------------------------------------------
// cdr_win_err_acc
//   Windowed |f_n| accumulator. Adds |f_n| on every sample_en strobe and,
//   after 2^WIN_LOG2 strobes, publishes the window total on win_sum with a
//   one-cycle win_done pulse. The final strobe's sample is part of the total;
//   the accumulator restarts from 0 (or from a strobe arriving in the
//   win_done cycle).
//
// Ports
//   clk, rst   : clock, asynchronous active-high reset
//   clr        : synchronous clear of the partial window (win_sum is kept)
//   sample_en  : one-cycle sample strobe
//   f_n        : signed phase error, valid with sample_en
//   win_done   : one-cycle pulse, the cycle after a window's last strobe
//   win_sum    : last completed window total, unsigned
// ---------------------------------------------------------------------------
module cdr_win_err_acc
  import cdr_ctrl_pkg::*;
#(
  parameter int WIN_LOG2 = WIN_LOG2_DEF,
  parameter int ERR_W    = ERR_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      sample_en,
  input  logic signed [ERR_W-1:0]   f_n,
  output logic                      win_done,
  output logic [ERR_W+WIN_LOG2-1:0] win_sum
);

  localparam int ACC_W = ERR_W + WIN_LOG2;

  logic [ACC_W-1:0]    acc_q;
  logic [WIN_LOG2-1:0] cnt_q;
  logic [ERR_W-1:0]    f_abs;
  logic [ACC_W-1:0]    acc_add;

  // Two's-complement negate as unsigned: the most negative code maps to
  // 2^(ERR_W-1), which still fits in ERR_W unsigned bits.
  assign f_abs   = f_n[ERR_W-1] ? (~f_n + ERR_W'(1)) : f_n;
  // ACC_W = ERR_W + WIN_LOG2, so 2^WIN_LOG2 maximal samples cannot overflow.
  assign acc_add = acc_q + ACC_W'(f_abs);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      win_done <= 1'b0;
      win_sum  <= '0;
    end else if (clr) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      win_done <= 1'b0;
    end else begin
      win_done <= 1'b0;
      if (sample_en) begin
        if (&cnt_q) begin
          win_sum  <= acc_add;
          win_done <= 1'b1;
          acc_q    <= '0;
          cnt_q    <= '0;
        end else begin
          acc_q <= acc_add;
          cnt_q <= cnt_q + WIN_LOG2'(1);
        end
      end
    end
  end

endmodule

// File: rtl/cdr_acq_ctrl.sv
// ---------------------------------------------------------------------------
// cdr_acq_ctrl
//   Acquisition/lock sequencer for the CDR loop. Classifies each completed
//   error window as good/bad/neutral, tracks run lengths and the acquisition
//   timeout, and sequences IDLE -> ACQ -> TRACK -> LOCK, gear-shifting the
//   PI loop-filter gains and issuing loop-filter clears.
//
//   All outputs are registered; state and gains change on the cycle after
//   win_done, so gains are constant within a window.
//
// Ports
//   clk, rst   : clock, asynchronous active-high reset
//   en         : controller enable; low forces IDLE and clears everything
//   sample_en  : recovered-timing strobe (1 clk)
//   f_n        : signed MMPD phase error, valid on sample_en
//   kp_shift   : proportional shift to loop filter
//   ki_shift   : integral shift to loop filter
//   lf_clr     : loop-filter clear (level in IDLE, 1-cycle pulse on restart)
//   locked     : high only in LOCK
//   state      : IDLE=0 ACQ=1 TRACK=2 LOCK=3
//   win_sum    : last completed window sum of |f_n|
// ---------------------------------------------------------------------------
module cdr_acq_ctrl
  import cdr_ctrl_pkg::*;
#(
  parameter int WIN_LOG2   = WIN_LOG2_DEF,
  parameter int ERR_W      = ERR_W_DEF,
  parameter int LOCK_THR   = LOCK_THR_DEF,
  parameter int UNLOCK_THR = UNLOCK_THR_DEF,
  parameter int GEAR_WINS  = GEAR_WINS_DEF,
  parameter int LOCK_WINS  = LOCK_WINS_DEF,
  parameter int LOSS_WINS  = LOSS_WINS_DEF,
  parameter int ACQ_TMO    = ACQ_TMO_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      sample_en,
  input  logic signed [ERR_W-1:0]   f_n,
  output logic [3:0]                kp_shift,
  output logic [4:0]                ki_shift,
  output logic                      lf_clr,
  output logic                      locked,
  output logic [1:0]                state,
  output logic [ERR_W+WIN_LOG2-1:0] win_sum
);

  localparam int ACC_W = ERR_W + WIN_LOG2;
  localparam int TMO_W = $clog2(ACQ_TMO + 1);

  localparam logic [ACC_W-1:0] LOCK_THR_V   = ACC_W'(LOCK_THR);
  localparam logic [ACC_W-1:0] UNLOCK_THR_V = ACC_W'(UNLOCK_THR);
  localparam logic [RUN_W-1:0] GEAR_V       = RUN_W'(GEAR_WINS);
  localparam logic [RUN_W-1:0] LOCK_V       = RUN_W'(LOCK_WINS);
  localparam logic [RUN_W-1:0] LOSS_V       = RUN_W'(LOSS_WINS);
  localparam logic [TMO_W-1:0] TMO_V        = TMO_W'(ACQ_TMO);

  cdr_state_t       state_q, state_nxt;
  logic [RUN_W-1:0] good_q, good_nxt, good_inc;
  logic [RUN_W-1:0] bad_q, bad_nxt, bad_inc;
  logic [TMO_W-1:0] tmo_q, tmo_nxt;
  logic             clr_pulse;
  win_cls_t         cls;

  logic             win_done;
  logic [ACC_W-1:0] win_sum_w;

  // Dropping en discards the partial window; strobes while disabled are ignored.
  cdr_win_err_acc #(
    .WIN_LOG2 (WIN_LOG2),
    .ERR_W    (ERR_W)
  ) u_acc (
    .clk       (clk),
    .rst       (rst),
    .clr       (~en),
    .sample_en (sample_en),
    .f_n       (f_n),
    .win_done  (win_done),
    .win_sum   (win_sum_w)
  );

  assign win_sum = win_sum_w;
  assign state   = state_q;

  // Saturating run increments (good runs keep growing while in LOCK).
  assign good_inc = (&good_q) ? good_q : good_q + RUN_W'(1);
  assign bad_inc  = (&bad_q)  ? bad_q  : bad_q  + RUN_W'(1);

  always_comb begin
    cls = CLS_NEUTRAL;
    if (win_sum_w < LOCK_THR_V) begin
      cls = CLS_GOOD;
    end else if (win_sum_w >= UNLOCK_THR_V) begin
      cls = CLS_BAD;
    end
  end

  // Next state, run/timeout counters and restart-clear pulse.
  // en=0 has priority over anything a coincident win_done would do.
  always_comb begin
    state_nxt = state_q;
    good_nxt  = good_q;
    bad_nxt   = bad_q;
    tmo_nxt   = tmo_q;
    clr_pulse = 1'b0;

    if (!en) begin
      state_nxt = ST_IDLE;
      good_nxt  = '0;
      bad_nxt   = '0;
      tmo_nxt   = '0;
    end else if (state_q == ST_IDLE) begin
      state_nxt = ST_ACQ;
      good_nxt  = '0;
      bad_nxt   = '0;
      tmo_nxt   = '0;
    end else if (win_done) begin
      unique case (cls)
        CLS_GOOD: begin
          good_nxt = good_inc;
          bad_nxt  = '0;
        end
        CLS_BAD: begin
          bad_nxt  = bad_inc;
          good_nxt = '0;
        end
        default: begin
          good_nxt = '0;
          bad_nxt  = '0;
        end
      endcase

      unique case (state_q)
        ST_ACQ: begin
          tmo_nxt = tmo_q + TMO_W'(1);
          // Gear-shift wins over a timeout in the same window.
          if (good_nxt == GEAR_V) begin
            state_nxt = ST_TRACK;
          end else if (tmo_nxt == TMO_V) begin
            clr_pulse = 1'b1;
            good_nxt  = '0;
            bad_nxt   = '0;
            tmo_nxt   = '0;
          end
        end
        ST_TRACK: begin
          if (good_nxt == LOCK_V) begin
            state_nxt = ST_LOCK;
          end else if (bad_nxt == LOSS_V) begin
            state_nxt = ST_ACQ;
          end
        end
        ST_LOCK: begin
          if (bad_nxt == LOSS_V) begin
            state_nxt = ST_ACQ;
            clr_pulse = 1'b1;
          end
        end
        default: ;
      endcase

      // Every state change starts fresh runs and a fresh timeout.
      if (state_nxt != state_q) begin
        good_nxt = '0;
        bad_nxt  = '0;
        tmo_nxt  = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      good_q   <= '0;
      bad_q    <= '0;
      tmo_q    <= '0;
      kp_shift <= KP_ACQ;
      ki_shift <= KI_ACQ;
      lf_clr   <= 1'b1;
      locked   <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      good_q   <= good_nxt;
      bad_q    <= bad_nxt;
      tmo_q    <= tmo_nxt;
      kp_shift <= kp_for(state_nxt);
      ki_shift <= ki_for(state_nxt);
      lf_clr   <= (state_nxt == ST_IDLE) | clr_pulse;
      locked   <= (state_nxt == ST_LOCK);
    end
  end

endmodule

// File: tb/tb_cdr_acq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cdr_acq_ctrl
//   Randomised-data bench for cdr_acq_ctrl. A behavioural model built from
//   the window/run/timeout rules predicts every output each cycle; a few
//   hand-computed literals pin the model at key points of each scenario.
// ---------------------------------------------------------------------------
module tb_cdr_acq_ctrl;

  // ---------------- clock / reset ----------------
  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               en = 1'b0;
  logic               sample_en = 1'b0;
  logic signed [15:0] f_n = '0;
  logic [3:0]         kp_shift;
  logic [4:0]         ki_shift;
  logic               lf_clr;
  logic               locked;
  logic [1:0]         state;
  logic [19:0]        win_sum;

  always #5 clk = ~clk;

  cdr_acq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .sample_en (sample_en),
    .f_n       (f_n),
    .kp_shift  (kp_shift),
    .ki_shift  (ki_shift),
    .lf_clr    (lf_clr),
    .locked    (locked),
    .state     (state),
    .win_sum   (win_sum)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit ready    = 1'b0;
  int clr_cycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Mode numbers: 0 idle, 1 acquiring, 2 tracking, 3 locked.
  int          m_mode = 0, m_cnt = 0, m_sum = 0, m_good = 0, m_bad = 0, m_tmo = 0;
  bit          m_pend = 1'b0, m_pulse = 1'b0;
  int          m_pend_sum = 0;
  logic [19:0] e_win_sum = '0;

  task automatic judge_window(input int s);
    if (s < 256) begin
      m_good++; m_bad = 0;
    end else if (s >= 1024) begin
      m_bad++; m_good = 0;
    end else begin
      m_good = 0; m_bad = 0;
    end
    if (m_mode == 1) begin
      m_tmo++;
      if (m_good == 4) begin
        m_mode = 2; m_good = 0; m_bad = 0; m_tmo = 0;
      end else if (m_tmo == 64) begin
        m_pulse = 1'b1; m_good = 0; m_bad = 0; m_tmo = 0;
      end
    end else if (m_mode == 2) begin
      if (m_good == 8) begin
        m_mode = 3; m_good = 0; m_bad = 0;
      end else if (m_bad == 2) begin
        m_mode = 1; m_good = 0; m_bad = 0; m_tmo = 0;
      end
    end else if (m_mode == 3) begin
      if (m_bad == 2) begin
        m_mode = 1; m_pulse = 1'b1; m_good = 0; m_bad = 0; m_tmo = 0;
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin : model
    int v;
    if (rst) begin
      m_mode = 0; m_cnt = 0; m_sum = 0; m_good = 0; m_bad = 0; m_tmo = 0;
      m_pend = 1'b0; m_pulse = 1'b0; e_win_sum = '0;
    end else begin
      m_pulse = 1'b0;
      if (!en) begin
        m_mode = 0; m_cnt = 0; m_sum = 0; m_good = 0; m_bad = 0; m_tmo = 0;
        m_pend = 1'b0;
      end else begin
        if (m_mode == 0) begin
          m_mode = 1; m_good = 0; m_bad = 0; m_tmo = 0;
        end else if (m_pend) begin
          judge_window(m_pend_sum);
        end
        m_pend = 1'b0;
        if (sample_en) begin
          v = int'(f_n);
          m_sum += (v < 0) ? -v : v;
          m_cnt++;
          if (m_cnt == 16) begin
            e_win_sum  = 20'(m_sum);
            m_pend     = 1'b1;
            m_pend_sum = m_sum;
            m_sum      = 0;
            m_cnt      = 0;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (ready) begin
      check("state",    state,    m_mode);
      check("kp_shift", kp_shift, (m_mode >= 2) ? 6 : 4);
      check("ki_shift", ki_shift, (m_mode >= 2) ? 12 : 10);
      check("lf_clr",   lf_clr,   ((m_mode == 0) || m_pulse) ? 1 : 0);
      check("locked",   locked,   (m_mode == 3) ? 1 : 0);
      check("win_sum",  win_sum,  e_win_sum);
      if (lf_clr) clr_cycles++;
    end
  end

  // ---------------- drivers ----------------
  task automatic cyc(input logic e, input logic s, input logic signed [15:0] f);
    en = e; sample_en = s; f_n = f;
    @(posedge clk);
    #1;
  endtask

  // n strobes with random gaps; magnitude in [lo,hi], optional random sign.
  task automatic strobes(input int n, input int lo, input int hi, input bit rs);
    int m;
    logic signed [15:0] v;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) cyc(1'b1, 1'b0, 16'($urandom));
      m = lo + int'($urandom_range(0, hi - lo));
      v = (rs && $urandom_range(0, 1) == 1) ? 16'(-m) : 16'(m);
      cyc(1'b1, 1'b1, v);
    end
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int c0;
    #2 rst = 1'b1;
    ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", state, 0);
    check("rst_kp", kp_shift, 4);
    check("rst_ki", ki_shift, 10);
    check("rst_lf_clr", lf_clr, 1);
    check("rst_locked", locked, 0);
    check("rst_win_sum", win_sum, 0);
    rst = 1'b0;

    // 1: clean error -> TRACK after 4 windows, LOCK after 8 more
    strobes(64, 0, 10, 1'b1);
    repeat (3) cyc(1'b1, 1'b0, '0);
    check("t1_track_state", state, 2);
    check("t1_track_kp", kp_shift, 6);
    check("t1_track_ki", ki_shift, 12);
    strobes(128, 0, 10, 1'b1);
    repeat (3) cyc(1'b1, 1'b0, '0);
    check("t1_lock_state", state, 3);
    check("t1_locked", locked, 1);

    // 2: large error from LOCK -> back to ACQ with a single clear cycle
    c0 = clr_cycles;
    strobes(32, 100, 100, 1'b0);
    repeat (3) cyc(1'b1, 1'b0, '0);
    check("t2_state", state, 1);
    check("t2_kp", kp_shift, 4);
    check("t2_clr_cycles", clr_cycles - c0, 1);
    check("t2_win_sum", win_sum, 1600);

    // 3: neutral windows -> no gear shift, timeout pulse after 64 windows
    c0 = clr_cycles;
    strobes(1024, 20, 50, 1'b1);
    repeat (3) cyc(1'b1, 1'b0, '0);
    check("t3_state", state, 1);
    check("t3_clr_cycles", clr_cycles - c0, 1);

    // 4: full-scale negative error -> no overflow
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b1, 16'sh8000);
    repeat (2) cyc(1'b1, 1'b0, '0);
    check("t4_win_sum", win_sum, 524288);
    check("t4_state", state, 1);

    // 5: en drops in the win_done cycle of the 4th good window
    strobes(63, 0, 10, 1'b1);
    cyc(1'b1, 1'b1, 16'sd3);
    cyc(1'b0, 1'b0, '0);
    check("t5_state", state, 0);
    check("t5_lf_clr", lf_clr, 1);
    repeat (2) cyc(1'b0, 1'b1, 16'sd7);
    check("t5_state_hold", state, 0);
    repeat (2) cyc(1'b1, 1'b0, '0);
    check("t5_reacq", state, 1);

    // 6: async reset mid-window, then a fresh 16-strobe window
    strobes(8, 0, 10, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("t6_state", state, 0);
    check("t6_lf_clr", lf_clr, 1);
    check("t6_kp", kp_shift, 4);
    check("t6_win_sum", win_sum, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    strobes(15, 5, 5, 1'b0);
    repeat (3) cyc(1'b1, 1'b0, '0);
    check("t6_no_early_win", win_sum, 0);
    cyc(1'b1, 1'b1, 16'sd5);
    check("t6_first_win", win_sum, 80);
    repeat (3) cyc(1'b1, 1'b0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
